// File: rtl/strobe_div_multi_if.sv
// Divisor-write bus shared between the strobe generator and its host.
// The host drives the write; the generator answers with a reject pulse.
interface strobe_div_multi_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic             div_wr;
   logic [CW-1:0]    div_ch;
   logic [WIDTH-1:0] div_data;
   logic             wr_err;

   modport master (output div_wr, div_ch, div_data, input wr_err);
   modport slave  (input div_wr, div_ch, div_data, output wr_err);
endinterface

// File: rtl/strobe_div_multi.sv
// Multi-channel programmable strobe generator with shadowed divisors,
// global sync restart and rejected-write reporting.
module strobe_div_lane #(
   parameter int WIDTH     = 16,
   parameter int RESET_DIV = 10
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_enable,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic             o_strobe
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] act_q, act_d;
   logic [WIDTH-1:0] pend_q, pend_d;

   assign o_strobe = (cnt_q == act_q - WIDTH'(1));

   // The active divisor only moves at a period boundary (wrap, disable or sync),
   // and a write landing on that boundary is picked up immediately.
   always_comb begin
      pend_d = i_wr ? i_wr_data : pend_q;
      cnt_d  = cnt_q + WIDTH'(1);
      act_d  = act_q;
      if (i_sync || !i_enable || o_strobe) begin
         cnt_d = '0;
         act_d = pend_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q  <= '0;
         act_q  <= WIDTH'(RESET_DIV);
         pend_q <= WIDTH'(RESET_DIV);
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         pend_q <= pend_d;
      end
   end
endmodule

module strobe_div_multi #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 16,
   parameter int RESET_DIV = 10
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic [CHANNELS-1:0] i_enable,
   input  logic                i_sync,
   strobe_div_multi_if.slave   wr_bus,
   output logic [CHANNELS-1:0] o_strobe
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   if (CHANNELS < 1) begin : g_chk_ch
      $error("strobe_div_multi: CHANNELS must be >= 1");
   end
   if ((RESET_DIV < 2) || (64'(RESET_DIV) > ((64'd1 << WIDTH) - 64'd1))) begin : g_chk_div
      $error("strobe_div_multi: RESET_DIV out of range");
   end

   logic ch_ok;
   logic acc;
   logic wr_err_q;

   // Channel range check is only needed when the select field can encode
   // indices beyond the last channel.
   if ((1 << CW) > CHANNELS) begin : g_ch_range
      assign ch_ok = (wr_bus.div_ch < CW'(CHANNELS));
   end else begin : g_ch_full
      assign ch_ok = 1'b1;
   end

   assign acc = wr_bus.div_wr && ch_ok && (wr_bus.div_data >= WIDTH'(2));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) wr_err_q <= 1'b0;
      else            wr_err_q <= wr_bus.div_wr && !acc;
   end

   assign wr_bus.wr_err = wr_err_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      logic lane_wr;
      assign lane_wr = acc && (wr_bus.div_ch == CW'(c));

      strobe_div_lane #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) u_lane (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_enable  (i_enable[c]),
         .i_sync    (i_sync),
         .i_wr      (lane_wr),
         .i_wr_data (wr_bus.div_data),
         .o_strobe  (o_strobe[c])
      );
   end
endmodule
